// File: rtl/uart_alici.sv
// 8N1 UART receiver with mid-bit sampling and a receive FIFO drained by a
// valid/consume handshake. Framing errors and overruns are one-cycle pulses.
module uart_alici #(
    parameter int FIFO_DERINLIK = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           rx_en_i,
    input  logic                           rx_i,
    input  logic [15:0]                    baud_div_i,
    output logic [7:0]                     veri_o,
    output logic                           veri_gecerli_o,
    input  logic                           tuket_i,
    output logic [$clog2(FIFO_DERINLIK):0] doluluk_o,
    output logic                           cerceve_hata_o,
    output logic                           tasma_o
);

    localparam int AW = $clog2(FIFO_DERINLIK);
    localparam logic [AW:0] DERINLIK_W = (AW+1)'(FIFO_DERINLIK);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        BASLA = 2'd1,
        VERI  = 2'd2,
        DUR   = 2'd3
    } durum_t;

    durum_t      durum_q;
    logic        rx_m_q;
    logic        rx_s_q;
    logic [15:0] sayac_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  kaydirma_q;
    logic        cerceve_hata_q;
    logic        tasma_q;

    logic [7:0]  mem_q [FIFO_DERINLIK];
    logic [AW:0] rd_q;
    logic [AW:0] wr_q;
    logic [AW:0] rd_d;
    logic [AW:0] wr_d;
    logic [7:0]  veri_q;
    logic [7:0]  veri_d;
    logic        gecerli_q;
    logic [AW:0] doluluk_q;

    logic [15:0] period_s;
    logic        bitti_s;
    logic        push_req_s;
    logic        stop_hata_s;
    logic        bos_s;
    logic        dolu_s;
    logic        pop_s;
    logic        push_ok_s;

    // Two-flop synchronizer; both stages reset to the idle line level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            rx_m_q <= rx_i;
            rx_s_q <= rx_m_q;
        end
    end

    // Bit timing, stop-bit decisions and FIFO handshake terms
    always_comb begin
        period_s    = (durum_q == BASLA) ? {1'b0, baud_div_i[15:1]} : baud_div_i;
        bitti_s     = (sayac_q == (period_s - 16'd1));
        push_req_s  = rx_en_i && (durum_q == DUR) && bitti_s && rx_s_q;
        stop_hata_s = rx_en_i && (durum_q == DUR) && bitti_s && !rx_s_q;
        bos_s       = (wr_q == rd_q);
        dolu_s      = ((wr_q - rd_q) == DERINLIK_W);
        pop_s       = tuket_i && !bos_s;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept
        push_ok_s   = push_req_s && (!dolu_s || pop_s);
        rd_d        = rd_q + {{AW{1'b0}}, pop_s};
        wr_d        = wr_q + {{AW{1'b0}}, push_ok_s};
    end

    // Receive state machine with registered error pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q        <= BOSTA;
            sayac_q        <= 16'd0;
            bit_idx_q      <= 3'd0;
            kaydirma_q     <= 8'h00;
            cerceve_hata_q <= 1'b0;
            tasma_q        <= 1'b0;
        end else begin
            cerceve_hata_q <= stop_hata_s;
            tasma_q        <= push_req_s && !push_ok_s;
            case (durum_q)
                BOSTA: begin
                    sayac_q   <= 16'd0;
                    bit_idx_q <= 3'd0;
                    if (rx_en_i && !rx_s_q) begin
                        durum_q <= BASLA;
                    end
                end
                BASLA: begin
                    if (!rx_en_i) begin
                        durum_q <= BOSTA;
                        sayac_q <= 16'd0;
                    end else if (bitti_s) begin
                        sayac_q <= 16'd0;
                        durum_q <= rx_s_q ? BOSTA : VERI;
                    end else begin
                        sayac_q <= sayac_q + 16'd1;
                    end
                end
                VERI: begin
                    if (!rx_en_i) begin
                        durum_q <= BOSTA;
                        sayac_q <= 16'd0;
                    end else if (bitti_s) begin
                        sayac_q               <= 16'd0;
                        kaydirma_q[bit_idx_q] <= rx_s_q;
                        bit_idx_q             <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            durum_q <= DUR;
                        end
                    end else begin
                        sayac_q <= sayac_q + 16'd1;
                    end
                end
                DUR: begin
                    if (!rx_en_i || bitti_s) begin
                        durum_q <= BOSTA;
                        sayac_q <= 16'd0;
                    end else begin
                        sayac_q <= sayac_q + 16'd1;
                    end
                end
                default: begin
                    durum_q   <= BOSTA;
                    sayac_q   <= 16'd0;
                    bit_idx_q <= 3'd0;
                end
            endcase
        end
    end

    // Next FIFO head; a byte pushed into the head slot bypasses the array
    always_comb begin
        if (wr_d == rd_d) begin
            veri_d = 8'h00;
        end else if (push_ok_s && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
            veri_d = kaydirma_q;
        end else begin
            veri_d = mem_q[rd_d[AW-1:0]];
        end
    end

    // FIFO storage array
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_q[AW-1:0]] <= kaydirma_q;
        end
    end

    // FIFO pointers and registered bus-side outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q      <= '0;
            wr_q      <= '0;
            veri_q    <= 8'h00;
            gecerli_q <= 1'b0;
            doluluk_q <= '0;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            veri_q    <= veri_d;
            gecerli_q <= (wr_d != rd_d);
            doluluk_q <= wr_d - rd_d;
        end
    end

    assign veri_o         = veri_q;
    assign veri_gecerli_o = gecerli_q;
    assign doluluk_o      = doluluk_q;
    assign cerceve_hata_o = cerceve_hata_q;
    assign tasma_o        = tasma_q;

endmodule

// File: tb/tb_uart_alici.sv
// Directed and randomized bench for uart_alici, compared against a queue
// model of the FIFO and frame rules.
module tb_uart_alici;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en;
    logic        rx;
    logic [15:0] baud;
    logic [7:0]  veri;
    logic        veri_gecerli;
    logic        tuket;
    logic [3:0]  doluluk;
    logic        cerceve_hata;
    logic        tasma;

    uart_alici #(.FIFO_DERINLIK(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_en_i        (rx_en),
        .rx_i           (rx),
        .baud_div_i     (baud),
        .veri_o         (veri),
        .veri_gecerli_o (veri_gecerli),
        .tuket_i        (tuket),
        .doluluk_o      (doluluk),
        .cerceve_hata_o (cerceve_hata),
        .tasma_o        (tasma)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int unsigned cyc = 0;
    int unsigned t0 = 0;
    int unsigned t_a = 0;
    int unsigned rise_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int wide_cnt = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    logic fe_p = 1'b0;
    logic ov_p = 1'b0;
    logic v_p = 1'b0;
    logic [7:0] q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counting, pulse-width and valid-rise monitor (mid-cycle)
    always @(negedge clk) begin
        if (cerceve_hata) fe_cnt++;
        if (tasma) ov_cnt++;
        if ((cerceve_hata && fe_p) || (tasma && ov_p)) wide_cnt++;
        if (veri_gecerli && !v_p) rise_cyc = cyc;
        fe_p = cerceve_hata;
        ov_p = tasma;
        v_p  = veri_gecerli;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_doluluk"}, 32'(doluluk), 32'(q.size()));
        chk({tag, "_gecerli"}, 32'(veri_gecerli), 32'(q.size() != 0));
        chk({tag, "_veri"}, 32'(veri), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, "_cerceve"}, 32'(fe_cnt), 32'(exp_fe));
        chk({tag, "_tasma"}, 32'(ov_cnt), 32'(exp_ov));
        chk({tag, "_genislik"}, 32'(wide_cnt), 32'd0);
    endtask

    // Frame outcome by the receiver rules: pop first, then push or flag
    task automatic model_rx(input logic [7:0] b, input logic stop, input logic popped);
        if (popped && q.size() > 0) void'(q.pop_front());
        if (!stop) exp_fe++;
        else if (q.size() < DEPTH) q.push_back(b);
        else exp_ov++;
    endtask

    task automatic pop_one();
        @(posedge clk); #1;
        tuket = 1'b1;
        @(posedge clk); #1;
        tuket = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int tail,
                              input int abort_bit, input int rst_bit, input logic pop_stop);
        int bw;
        int len;
        logic [9:0] fr;
        bw  = int'(baud);
        len = 10 * bw + tail;
        fr  = {stop, b, 1'b0};
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            if (c == 0) t0 = cyc;
            rx    = (c < 10 * bw) ? fr[c / bw] : 1'b1;
            rst   = (rst_bit >= 0) && (c == rst_bit * bw + bw / 2);
            tuket = pop_stop && (c == 2 + bw / 2 + 9 * bw);
            if (abort_bit >= 0 && c == abort_bit * bw + bw / 2) rx_en = 1'b0;
        end
        rx_en = 1'b1;
        rst   = 1'b0;
        tuket = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            pop_one();
            check_model(tag);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       s;
        rst   = 1'b1;
        rx    = 1'b1;
        rx_en = 1'b1;
        tuket = 1'b0;
        baud  = 16'd16;
        idle(3);
        chk("rst_veri", 32'(veri), 32'd0);
        chk("rst_gecerli", 32'(veri_gecerli), 32'd0);
        chk("rst_doluluk", 32'(doluluk), 32'd0);
        chk("rst_cerceve", 32'(cerceve_hata), 32'd0);
        chk("rst_tasma", 32'(tasma), 32'd0);
        rst = 1'b0;
        idle(2);

        // Back-to-back frames, then consume
        send_frame(8'h55, 1'b1, 0, -1, -1, 1'b0);
        t_a = t0;
        model_rx(8'h55, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 16, -1, -1, 1'b0);
        model_rx(8'hA3, 1'b1, 1'b0);
        check_model("b2b");
        chk("b2b_latency", rise_cyc - t_a, 32'(3 + 8 + 9 * 16));
        pop_one();
        check_model("b2b_pop");
        chk("b2b_pop_A3", 32'(veri), 32'hA3);
        drain("b2b_drain");

        // Short low glitch while idle, then a real frame
        @(posedge clk); #1;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        check_model("glitch");
        send_frame(8'h0F, 1'b1, 16, -1, -1, 1'b0);
        model_rx(8'h0F, 1'b1, 1'b0);
        check_model("after_glitch");
        drain("glitch_drain");

        // Stop bit driven low
        send_frame(8'hFF, 1'b0, 16, -1, -1, 1'b0);
        model_rx(8'hFF, 1'b0, 1'b0);
        check_model("framing");

        // Randomized frames, divisors and pops
        for (int i = 0; i < 8; i++) begin
            baud = 16'($urandom_range(4, 24));
            b    = 8'($urandom);
            s    = ($urandom_range(0, 4) != 0);
            send_frame(b, s, int'(baud), -1, -1, 1'b0);
            model_rx(b, s, 1'b0);
            check_model("rand");
            if ($urandom_range(0, 1) == 1) begin
                pop_one();
                check_model("rand_pop");
            end
        end
        drain("rand_drain");

        // Overflow on the ninth frame, then the same with a pop on the push cycle
        baud = 16'd16;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 16, -1, -1, 1'b0);
            model_rx(b, 1'b1, 1'b0);
        end
        check_model("overflow");
        chk("overflow_full", 32'(doluluk), 32'd8);
        drain("overflow_drain");
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 16, -1, -1, (i == 8));
            model_rx(b, 1'b1, (i == 8));
        end
        check_model("full_pop");
        chk("full_pop_level", 32'(doluluk), 32'd8);
        drain("full_pop_drain");

        // Enable dropped in data bit 4, then reset in data bit 2 of the next frame
        send_frame(8'h3C, 1'b1, 16, 5, -1, 1'b0);
        check_model("abort");
        send_frame(8'h5A, 1'b1, 16, -1, -1, 1'b0);
        model_rx(8'h5A, 1'b1, 1'b0);
        check_model("pre_rst");
        send_frame(8'hFC, 1'b1, 16, -1, 3, 1'b0);
        q.delete();
        check_model("mid_rst");
        chk("mid_rst_cerceve", 32'(cerceve_hata), 32'd0);
        chk("mid_rst_tasma", 32'(tasma), 32'd0);
        send_frame(8'hC6, 1'b1, 16, -1, -1, 1'b0);
        model_rx(8'hC6, 1'b1, 1'b0);
        check_model("after_rst");
        drain("rst_drain");

        // Minimum divisor with exact sample timing
        baud = 16'd4;
        send_frame(8'h81, 1'b1, 4, -1, -1, 1'b0);
        model_rx(8'h81, 1'b1, 1'b0);
        check_model("min_baud");
        chk("min_baud_latency", rise_cyc - t0, 32'(3 + 2 + 9 * 4));
        drain("min_baud_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
